gomoku_board_engine: RTL and testbench

GOMOKU_BOARD_ENGINE -- requirements
Module: gomoku_board_engine

---
 rtl/gomoku_board_engine_if.sv | 14 +
 rtl/gomoku_board_engine.sv | 256 +++++++++++++++++++++++++
 tb/tb_gomoku_board_engine.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gomoku_board_engine_if.sv
// rtl/gomoku_board_engine_if.sv - move request / result handshake between a game controller and the board engine
interface gomoku_board_engine_if #(
  parameter int CW = 4
);
  logic          go;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          ready;
  logic          accepted;
  logic          rejected;

  modport master (output go, x, y, input ready, accepted, rejected);
  modport slave  (input go, x, y, output ready, accepted, rejected);
endinterface

// File: rtl/gomoku_board_engine.sv
// rtl/gomoku_board_engine.sv - gomoku board store, move legality and win/draw detection
// Optional macro GOMOKU_EXACT_WIN_EN: only a run of exactly WIN_LEN wins (overlines do not).
module gomoku_board_engine #(
  parameter int N       = 15,
  parameter int WIN_LEN = 5,
  parameter int CW      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  gomoku_board_engine_if.slave           bus,
  output logic                           color,
  output logic                           win,
  output logic                           win_color,
  output logic                           draw,
  output logic [$clog2(N*N+1)-1:0]       move_count,
  input  logic [CW-1:0]                  rd_x,
  input  logic [CW-1:0]                  rd_y,
  output logic [1:0]                     rd_cell
);

  localparam int CELLS = N * N;
  localparam int IW    = $clog2(CELLS);
  localparam int MCW   = $clog2(CELLS + 1);
  localparam int AW    = CW + 2;
  localparam int SW    = CW + 1;
  localparam int RW    = CW + 3;
`ifdef GOMOKU_EXACT_WIN_EN
  localparam int MAX_STEP = WIN_LEN;
`else
  localparam int MAX_STEP = WIN_LEN - 1;
`endif
  localparam logic [AW-1:0]  N_A        = AW'(N);
  localparam logic [SW-1:0]  MAX_STEP_S = SW'(MAX_STEP);
  localparam logic [RW-1:0]  WIN_R      = RW'(WIN_LEN);
  localparam logic [MCW-1:0] CELLS_M    = MCW'(CELLS);

  typedef enum logic [2:0] {S_IDLE, S_PLACE, S_SCAN, S_RESOLVE, S_OVER} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   px_q, px_d, py_q, py_d;
  logic            pc_q, pc_d;
  logic            color_q, color_d;
  logic            win_q, win_d, win_color_q, win_color_d, draw_q, draw_d;
  logic [MCW-1:0]  mc_q, mc_d;
  logic            acc_q, acc_d, rej_q, rej_d;
  logic [1:0]      dir_q, dir_d;
  logic            neg_q, neg_d;
  logic [SW-1:0]   step_q, step_d;
  logic [RW-1:0]   run_q, run_d;
  logic            hit_q, hit_d;
  logic [1:0]      cell_q [CELLS];

  function automatic logic [IW-1:0] cell_idx(input logic [AW-1:0] r, input logic [AW-1:0] c);
    return IW'(int'(r) * N + int'(c));
  endfunction

  logic [AW-1:0] px_a, py_a, k_a, row_a, col_a, req_x_a, req_y_a, rd_x_a, rd_y_a;
  logic          row_inc, row_dec, col_inc, col_dec, row_ok, col_ok, in_bounds;
  logic [IW-1:0] scan_idx, req_idx, rd_idx;
  logic [1:0]    scan_cell, stone;
  logic          match, sense_end, early_win, dir_win, req_in, rd_in;
  logic [RW-1:0] run_inc, run_now;

  // Candidate cell for this scan cycle: placed cell offset by step along the current direction/sense.
  always_comb begin
    px_a    = {2'b00, px_q};
    py_a    = {2'b00, py_q};
    k_a     = {1'b0, step_q};
    row_inc = 1'b0;
    row_dec = 1'b0;
    col_inc = 1'b0;
    col_dec = 1'b0;
    case (dir_q)
      2'd0:    col_inc = 1'b1;
      2'd1:    row_inc = 1'b1;
      2'd2:    begin row_inc = 1'b1; col_inc = 1'b1; end
      default: begin row_dec = 1'b1; col_inc = 1'b1; end
    endcase
    if (neg_q) begin
      {row_inc, row_dec} = {row_dec, row_inc};
      {col_inc, col_dec} = {col_dec, col_inc};
    end
    row_a  = px_a;
    row_ok = 1'b1;
    if (row_inc) begin
      row_a  = px_a + k_a;
      row_ok = row_a < N_A;
    end else if (row_dec) begin
      row_a  = px_a - k_a;
      row_ok = k_a <= px_a;
    end
    col_a  = py_a;
    col_ok = 1'b1;
    if (col_inc) begin
      col_a  = py_a + k_a;
      col_ok = col_a < N_A;
    end else if (col_dec) begin
      col_a  = py_a - k_a;
      col_ok = k_a <= py_a;
    end
    in_bounds = row_ok && col_ok;
    scan_idx  = in_bounds ? cell_idx(row_a, col_a) : '0;
    scan_cell = in_bounds ? cell_q[scan_idx] : 2'b00;
    stone     = {pc_q, ~pc_q};
    match     = in_bounds && (scan_cell == stone);
    run_inc   = run_q + RW'(1);
    run_now   = match ? run_inc : run_q;
    sense_end = !match || (step_q == MAX_STEP_S);
`ifdef GOMOKU_EXACT_WIN_EN
    early_win = 1'b0;
    dir_win   = neg_q && sense_end && (run_now == WIN_R);
`else
    early_win = match && (run_inc >= WIN_R);
    dir_win   = 1'b0;
`endif
  end

  always_comb begin
    req_x_a = {2'b00, bus.x};
    req_y_a = {2'b00, bus.y};
    req_in  = (req_x_a < N_A) && (req_y_a < N_A);
    req_idx = req_in ? cell_idx(req_x_a, req_y_a) : '0;
    rd_x_a  = {2'b00, rd_x};
    rd_y_a  = {2'b00, rd_y};
    rd_in   = (rd_x_a < N_A) && (rd_y_a < N_A);
    rd_idx  = rd_in ? cell_idx(rd_x_a, rd_y_a) : '0;
    rd_cell = rd_in ? cell_q[rd_idx] : 2'b00;
  end

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    pc_d        = pc_q;
    color_d     = color_q;
    win_d       = win_q;
    win_color_d = win_color_q;
    draw_d      = draw_q;
    mc_d        = mc_q;
    acc_d       = 1'b0;
    rej_d       = 1'b0;
    dir_d       = dir_q;
    neg_d       = neg_q;
    step_d      = step_q;
    run_d       = run_q;
    hit_d       = hit_q;
    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          if (!req_in || (cell_q[req_idx] != 2'b00)) begin
            rej_d = 1'b1;
          end else begin
            px_d    = bus.x;
            py_d    = bus.y;
            pc_d    = color_q;
            state_d = S_PLACE;
          end
        end
      end
      S_PLACE: begin
        acc_d   = 1'b1;
        mc_d    = mc_q + MCW'(1);
        dir_d   = 2'd0;
        neg_d   = 1'b0;
        step_d  = SW'(1);
        run_d   = RW'(1);
        hit_d   = 1'b0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        run_d  = run_now;
        step_d = step_q + SW'(1);
        if (early_win || dir_win) begin
          hit_d   = 1'b1;
          state_d = S_RESOLVE;
        end else if (sense_end) begin
          step_d = SW'(1);
          if (!neg_q) begin
            neg_d = 1'b1;
          end else if (dir_q == 2'd3) begin
            state_d = S_RESOLVE;
          end else begin
            dir_d = dir_q + 2'd1;
            neg_d = 1'b0;
            run_d = RW'(1);
          end
        end
      end
      S_RESOLVE: begin
        if (hit_q) begin
          win_d       = 1'b1;
          win_color_d = pc_q;
          state_d     = S_OVER;
        end else if (mc_q == CELLS_M) begin
          draw_d  = 1'b1;
          state_d = S_OVER;
        end else begin
          color_d = ~color_q;
          state_d = S_IDLE;
        end
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      px_q        <= '0;
      py_q        <= '0;
      pc_q        <= 1'b0;
      color_q     <= 1'b0;
      win_q       <= 1'b0;
      win_color_q <= 1'b0;
      draw_q      <= 1'b0;
      mc_q        <= '0;
      acc_q       <= 1'b0;
      rej_q       <= 1'b0;
      dir_q       <= 2'd0;
      neg_q       <= 1'b0;
      step_q      <= '0;
      run_q       <= '0;
      hit_q       <= 1'b0;
      for (int i = 0; i < CELLS; i++) cell_q[i] <= 2'b00;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pc_q        <= pc_d;
      color_q     <= color_d;
      win_q       <= win_d;
      win_color_q <= win_color_d;
      draw_q      <= draw_d;
      mc_q        <= mc_d;
      acc_q       <= acc_d;
      rej_q       <= rej_d;
      dir_q       <= dir_d;
      neg_q       <= neg_d;
      step_q      <= step_d;
      run_q       <= run_d;
      hit_q       <= hit_d;
      if (state_q == S_PLACE) cell_q[cell_idx(px_a, py_a)] <= stone;
    end
  end

  assign bus.ready    = (state_q == S_IDLE);
  assign bus.accepted = acc_q;
  assign bus.rejected = rej_q;
  assign color        = color_q;
  assign win          = win_q;
  assign win_color    = win_color_q;
  assign draw         = draw_q;
  assign move_count   = mc_q;

endmodule

// File: tb/tb_gomoku_board_engine.sv
// tb/tb_gomoku_board_engine.sv - directed checks of gomoku_board_engine (15x15 and 5x5 instances)
module tb_gomoku_board_engine;
  logic clk = 1'b0;
  logic rst, rst5;
  always #5 clk = ~clk;

  gomoku_board_engine_if #(.CW(4)) bif ();
  gomoku_board_engine_if #(.CW(4)) sif ();

  logic       b_color, b_win, b_win_color, b_draw;
  logic [7:0] b_mc;
  logic [3:0] b_rd_x, b_rd_y;
  logic [1:0] b_rd_cell;
  logic       s_color, s_win, s_win_color, s_draw;
  logic [4:0] s_mc;
  logic [3:0] s_rd_x, s_rd_y;
  logic [1:0] s_rd_cell;

  gomoku_board_engine #(.N(15), .WIN_LEN(5), .CW(4)) dut (
    .clk(clk), .reset(rst), .bus(bif), .color(b_color), .win(b_win),
    .win_color(b_win_color), .draw(b_draw), .move_count(b_mc),
    .rd_x(b_rd_x), .rd_y(b_rd_y), .rd_cell(b_rd_cell));

  gomoku_board_engine #(.N(5), .WIN_LEN(5), .CW(4)) dut5 (
    .clk(clk), .reset(rst5), .bus(sif), .color(s_color), .win(s_win),
    .win_color(s_win_color), .draw(s_draw), .move_count(s_mc),
    .rd_x(s_rd_x), .rd_y(s_rd_y), .rd_cell(s_rd_cell));

`ifdef GOMOKU_EXACT_WIN_EN
  localparam int SIX_WIN = 0;
`else
  localparam int SIX_WIN = 1;
`endif

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int mvx[$];
  int mvy[$];
  int b5x[13] = '{0, 0, 0, 1, 1, 2, 2, 2, 3, 3, 4, 4, 4};
  int b5y[13] = '{0, 1, 4, 2, 3, 0, 1, 4, 2, 3, 0, 1, 4};
  int w5x[12] = '{0, 0, 1, 1, 1, 2, 2, 3, 3, 3, 4, 4};
  int w5y[12] = '{2, 3, 0, 1, 4, 2, 3, 0, 1, 4, 2, 3};

  logic acc_s, rej_s, rdy_s, win_s, draw_s;
  assign acc_s  = (sel != 0) ? sif.accepted : bif.accepted;
  assign rej_s  = (sel != 0) ? sif.rejected : bif.rejected;
  assign rdy_s  = (sel != 0) ? sif.ready    : bif.ready;
  assign win_s  = (sel != 0) ? s_win        : b_win;
  assign draw_s = (sel != 0) ? s_draw       : b_draw;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic g, input int xx, input int yy);
    if (sel != 0) begin sif.go = g; sif.x = 4'(xx); sif.y = 4'(yy); end
    else          begin bif.go = g; bif.x = 4'(xx); bif.y = 4'(yy); end
  endtask

  task automatic rd(input int xx, input int yy, output int v);
    if (sel != 0) begin s_rd_x = 4'(xx); s_rd_y = 4'(yy); end
    else          begin b_rd_x = 4'(xx); b_rd_y = 4'(yy); end
    #1;
    v = (sel != 0) ? int'(s_rd_cell) : int'(b_rd_cell);
  endtask

  task automatic play(input int xx, input int yy, input int bx, input int by,
                      output int acc, output int rej, output int lat);
    int a_cyc;
    bit done;
    acc = 0; rej = 0; lat = -1; a_cyc = -1; done = 1'b0;
    @(negedge clk); drive(1'b1, xx, yy);
    @(negedge clk); drive(1'b0, xx, yy);
    for (int i = 1; i <= 100 && !done; i++) begin
      if (acc_s) begin acc = 1; a_cyc = i; end
      if (rej_s) rej = 1;
      if (i >= 3 && (rdy_s || win_s || draw_s)) begin
        done = 1'b1;
        if (a_cyc >= 0) lat = i - a_cyc;
      end else begin
        if (bx >= 0 && i == 3) drive(1'b1, bx, by);
        if (bx >= 0 && i == 4) drive(1'b0, bx, by);
        @(negedge clk);
      end
    end
    if (!done) check("play_timeout", 0, 1);
  endtask

  task automatic run_moves(output int nacc);
    int a, r, l;
    nacc = 0;
    for (int i = 0; i < mvx.size(); i++) begin
      play(mvx[i], mvy[i], -1, -1, a, r, l);
      nacc += a;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    if (sel != 0) rst5 = 1'b1; else rst = 1'b1;
    @(negedge clk);
    if (sel != 0) rst5 = 1'b0; else rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int a, r, l, v, n;
    rst = 1'b1; rst5 = 1'b1;
    bif.go = 1'b0; bif.x = '0; bif.y = '0;
    sif.go = 1'b0; sif.x = '0; sif.y = '0;
    b_rd_x = '0; b_rd_y = '0; s_rd_x = '0; s_rd_y = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst5 = 1'b0;
    @(negedge clk);

    check("rst_ready", bif.ready, 1);
    check("rst_color", b_color, 0);
    check("rst_win", b_win, 0);
    check("rst_draw", b_draw, 0);
    check("rst_mc", b_mc, 0);
    check("rst_acc", bif.accepted, 0);
    check("rst_rej", bif.rejected, 0);
    rd(7, 7, v); check("rst_cell", v, 0);

    play(7, 7, -1, -1, a, r, l);
    check("m1_acc", a, 1);
    check("m1_rej", r, 0);
    rd(7, 7, v); check("m1_cell", v, 1);
    check("m1_color", b_color, 1);
    check("m1_mc", b_mc, 1);
    check("m1_lat_le34", (l > 0 && l <= 34) ? 1 : 0, 1);

    play(7, 7, -1, -1, a, r, l);
    check("occ_rej", r, 1);
    check("occ_acc", a, 0);
    play(15, 0, -1, -1, a, r, l);
    check("oobx_rej", r, 1);
    play(0, 15, -1, -1, a, r, l);
    check("ooby_rej", r, 1);
    check("rej_mc", b_mc, 1);
    check("rej_color", b_color, 1);

    play(10, 10, 11, 11, a, r, l);
    check("busy_acc", a, 1);
    rd(11, 11, v); check("busy_ignored_cell", v, 0);
    rd(10, 10, v); check("white_cell", v, 2);
    check("busy_mc", b_mc, 2);
    check("busy_color", b_color, 0);

    mvx = '{3, 12, 3, 12, 3, 12, 3, 12, 3};
    mvy = '{0, 0, 1, 2, 2, 4, 3, 6, 4};
    run_moves(n);
    check("row_nacc", n, 9);
    check("row_win", b_win, 1);
    check("row_win_color", b_win_color, 0);
    check("row_draw", b_draw, 0);
    check("row_over_ready", bif.ready, 0);
    check("row_mc", b_mc, 11);
    rd(15, 3, v); check("rd_oob_row", v, 0);
    play(0, 0, -1, -1, a, r, l);
    check("over_acc", a, 0);
    check("over_rej", r, 0);
    check("over_mc", b_mc, 11);

    @(negedge clk);
    rst = 1'b1; drive(1'b1, 0, 0);
    #1;
    check("async_win_clr", b_win, 0);
    check("async_mc_clr", b_mc, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; drive(1'b0, 0, 0);
    @(negedge clk);
    check("post_rst_ready", bif.ready, 1);
    check("rstgo_mc", b_mc, 0);
    rd(0, 0, v); check("rstgo_cell", v, 0);
    rd(3, 4, v); check("rst_cells_clr", v, 0);

    mvx = '{0, 14, 1, 14, 2, 14, 3, 14, 4};
    mvy = '{0, 0, 1, 2, 2, 4, 3, 6, 4};
    run_moves(n);
    check("diag_win", b_win, 1);
    check("diag_win_color", b_win_color, 0);

    do_reset();
    mvx = '{0, 9, 0, 8, 0, 7, 0, 6, 0, 5};
    mvy = '{0, 5, 2, 6, 4, 7, 6, 8, 8, 9};
    run_moves(n);
    check("upright_win", b_win, 1);
    check("upright_win_color", b_win_color, 1);
    check("upright_mc", b_mc, 10);

    do_reset();
    mvx = '{0, 14, 0, 14, 0, 14, 0, 14, 1};
    mvy = '{11, 0, 12, 2, 13, 4, 14, 6, 0};
    run_moves(n);
    check("wrap_nacc", n, 9);
    check("wrap_no_win", b_win, 0);
    check("wrap_ready", bif.ready, 1);
    check("wrap_color", b_color, 1);
    rd(1, 0, v); check("wrap_cell_1_0", v, 1);
    rd(0, 15, v); check("rd_oob_col", v, 0);

    do_reset();
    mvx = '{5, 14, 5, 14, 5, 14, 5, 14, 5, 14, 5};
    mvy = '{0, 0, 1, 2, 2, 4, 4, 6, 5, 8, 3};
    run_moves(n);
    check("six_nacc", n, 11);
    check("six_win", b_win, SIX_WIN);

    sel = 1;
    mvx.delete(); mvy.delete();
    for (int i = 0; i < 25; i++) begin
      if (i % 2 == 0) begin mvx.push_back(b5x[i/2]); mvy.push_back(b5y[i/2]); end
      else            begin mvx.push_back(w5x[i/2]); mvy.push_back(w5y[i/2]); end
    end
    run_moves(n);
    check("draw_nacc", n, 25);
    check("draw_flag", s_draw, 1);
    check("draw_no_win", s_win, 0);
    check("draw_mc", s_mc, 25);
    check("draw_ready", sif.ready, 0);
    rd(4, 3, v); check("n5_cell_4_3", v, 2);
    rd(0, 5, v); check("n5_rd_oob_col", v, 0);
    rd(5, 0, v); check("n5_rd_oob_row", v, 0);

    do_reset();
    check("n5_rst_draw", s_draw, 0);
    @(negedge clk); drive(1'b1, 2, 2);
    @(negedge clk); drive(1'b0, 2, 2);
    @(negedge clk);
    check("abort_acc_seen", sif.accepted, 1);
    #2 rst5 = 1'b1;
    #1;
    rd(2, 2, v); check("abort_cell_clr", v, 0);
    check("abort_acc_clr", sif.accepted, 0);
    check("abort_mc", s_mc, 0);
    @(negedge clk); rst5 = 1'b0;
    @(negedge clk);
    check("abort_ready", sif.ready, 1);
    check("abort_color", s_color, 0);
    rd(2, 2, v); check("abort_cell_after", v, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
